// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Desc     : Shared SPI constants and receiver/transmitter state encoding.
// Revision : 1.0
// ============================================================================
package spi_pkg;

    localparam int c_data_w    = 16;
    localparam int c_bit_cnt_w = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync
// Desc     : Single-bit multi-flop synchronizer with a configurable idle value.
// Revision : 1.0
// ============================================================================
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    // Depths below two give no metastability protection, so they are raised.
    localparam int c_stages = (STAGES < 2) ? 2 : STAGES;

    logic [c_stages-1:0] r_chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_chain <= {c_stages{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[c_stages-2:0], i_async};
        end
    end

    assign o_sync = r_chain[c_stages-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_rx
// Desc     : SPI mode-0 slave receiver, oversampled in the clk domain.
// Revision : 1.0
// ============================================================================
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = c_data_w,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   spi_ssal,
    input  logic                   spi_mclk,
    input  logic                   spi_dat,
    output logic [DATA_W-1:0]      dat_out,
    output logic                   dat_valid,
    input  logic                   dat_ready,
    output logic [c_bit_cnt_w-1:0] bit_count,
    output logic                   frame_err,
    output logic                   overrun
);

    localparam int                     c_stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [c_bit_cnt_w-1:0] c_last   = c_bit_cnt_w'(DATA_W - 1);

    logic w_ssal_s;
    logic w_mclk_s;
    logic w_dat_s;

    spi_sync #(.STAGES(c_stages), .RESET_VAL(1'b1)) u_sync_ssal (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi_ssal),
        .o_sync  (w_ssal_s)
    );

    spi_sync #(.STAGES(c_stages), .RESET_VAL(1'b0)) u_sync_mclk (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi_mclk),
        .o_sync  (w_mclk_s)
    );

    spi_sync #(.STAGES(c_stages), .RESET_VAL(1'b0)) u_sync_dat (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi_dat),
        .o_sync  (w_dat_s)
    );

    logic                   r_ssal_prev;
    logic                   r_mclk_prev;
    logic [c_stages-1:0]    r_live;
    logic                   r_armed;
    spi_state_e             r_state;
    spi_state_e             w_state_next;
    logic                   w_sample;
    logic                   w_abort;
    logic                   w_mclk_rise;
    logic                   w_ssal_rise;
    logic                   w_ssal_fall;
    logic [DATA_W-1:0]      r_shift;
    logic [c_bit_cnt_w-1:0] r_bit_cnt;
    logic                   r_done;
    logic                   r_frame_err;
    logic [DATA_W-1:0]      r_dat_out;
    logic                   r_dat_valid;
    logic                   r_overrun;

    // The ssal chain leaves reset at its idle value; a select held low across
    // reset release must not look like a fresh falling edge, so falling edges
    // only count once ssal has been seen high with a fully flushed chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ssal_prev <= 1'b1;
            r_mclk_prev <= 1'b0;
            r_live      <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_ssal_prev <= w_ssal_s;
            r_mclk_prev <= w_mclk_s;
            r_live      <= {r_live[c_stages-2:0], 1'b1};
            r_armed     <= r_armed | (r_live[c_stages-1] & w_ssal_s);
        end
    end

    assign w_mclk_rise = w_mclk_s & ~r_mclk_prev;
    assign w_ssal_rise = w_ssal_s & ~r_ssal_prev;
    assign w_ssal_fall = ~w_ssal_s & r_ssal_prev & r_armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A sampling edge coincident with select deassertion is dropped.
    always_comb begin
        w_state_next = r_state;
        w_sample     = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ssal_fall) begin
                    w_state_next = RECV;
                end
            end
            RECV: begin
                if (w_ssal_rise) begin
                    w_state_next = IDLE;
                    w_abort      = (r_bit_cnt != '0);
                end else begin
                    w_sample = w_mclk_rise;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_frame_err <= w_abort;
            if (w_state_next == IDLE) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else if (w_sample) begin
                r_shift <= {r_shift[DATA_W-2:0], w_dat_s};
                if (r_bit_cnt == c_last) begin
                    r_bit_cnt <= '0;
                    r_done    <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + c_bit_cnt_w'(1);
                end
            end
        end
    end

    // The shifter cannot change again before r_done is consumed, because
    // mclk phases span at least two clk periods.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dat_out   <= '0;
            r_dat_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (r_done) begin
            r_dat_out   <= r_shift;
            r_dat_valid <= 1'b1;
            r_overrun   <= r_dat_valid & ~dat_ready;
        end else begin
            r_overrun <= 1'b0;
            if (r_dat_valid & dat_ready) begin
                r_dat_valid <= 1'b0;
            end
        end
    end

    assign dat_out   = r_dat_out;
    assign dat_valid = r_dat_valid;
    assign bit_count = r_bit_cnt;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_rx
// Desc     : Directed self-checking bench for spi_slave_rx.
// Revision : 1.0
// ============================================================================
module tb_spi_slave_rx;

    logic        clk;
    logic        rst;
    logic        spi_ssal;
    logic        spi_mclk;
    logic        spi_dat;
    logic [15:0] dat_out;
    logic        dat_valid;
    logic        dat_ready;
    logic [4:0]  bit_count;
    logic        frame_err;
    logic        overrun;

    int          n_checks;
    int          n_errors;
    int          n_got;
    int          n_ovr;
    int          n_ferr;
    logic [15:0] got_words [0:7];

    spi_slave_rx #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_ssal  (spi_ssal),
        .spi_mclk  (spi_mclk),
        .spi_dat   (spi_dat),
        .dat_out   (dat_out),
        .dat_valid (dat_valid),
        .dat_ready (dat_ready),
        .bit_count (bit_count),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake and pulse observers, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst && dat_valid && dat_ready) begin
            if (n_got < 8) got_words[n_got] = dat_out;
            n_got = n_got + 1;
        end
        if (overrun)   n_ovr  = n_ovr + 1;
        if (frame_err) n_ferr = n_ferr + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One mode-0 bit: data set in the low phase, 3 clk low then 3 clk high.
    task automatic send_bit(input logic b);
        @(negedge clk);
        spi_dat = b;
        repeat (2) @(negedge clk);
        spi_mclk = 1'b1;
        repeat (3) @(negedge clk);
        spi_mclk = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 15; i > 15 - n; i--) begin
            send_bit(w[i]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        n_got     = 0;
        n_ovr     = 0;
        n_ferr    = 0;
        rst       = 1'b0;
        spi_ssal  = 1'b1;
        spi_mclk  = 1'b0;
        spi_dat   = 1'b0;
        dat_ready = 1'b0;

        // Reset state
        idle(3);
        check("rst_dat_out",   dat_out,   16'h0000);
        check("rst_dat_valid", dat_valid, 1'b0);
        check("rst_bit_count", bit_count, 5'd0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun",   overrun,   1'b0);
        rst = 1'b1;
        idle(6);

        // Single word 16'hA563 with exact latency on the last bit
        spi_ssal = 1'b0;
        idle(3);
        send_bits(16'hA563, 15);
        check("a563_cnt15", bit_count, 5'd15);
        @(negedge clk);
        spi_dat = 1'b1;
        idle(2);
        spi_mclk = 1'b1;
        idle(3);
        check("a563_valid_early", dat_valid, 1'b0);
        idle(1);
        check("a563_valid", dat_valid, 1'b1);
        check("a563_data",  dat_out,   16'hA563);
        check("a563_cnt0",  bit_count, 5'd0);
        spi_mclk = 1'b0;
        dat_ready = 1'b1;
        idle(1);
        dat_ready = 1'b0;
        idle(1);
        check("a563_consumed", dat_valid, 1'b0);
        spi_ssal = 1'b1;
        idle(6);
        check("a563_no_ferr", n_ferr, 0);

        // Back-to-back 16'hFFFF, 16'h89DD with dat_ready held
        n_got = 0;
        n_ovr = 0;
        dat_ready = 1'b1;
        spi_ssal = 1'b0;
        idle(3);
        send_bits(16'hFFFF, 16);
        send_bits(16'h89DD, 16);
        idle(6);
        spi_ssal = 1'b1;
        idle(6);
        check("b2b_count", n_got, 2);
        check("b2b_w0",    got_words[0], 16'hFFFF);
        check("b2b_w1",    got_words[1], 16'h89DD);
        check("b2b_ovr",   n_ovr, 0);
        check("b2b_valid", dat_valid, 1'b0);
        check("b2b_ferr",  n_ferr, 0);

        // Overrun: 16'h246E then 16'hA563 with no consumer
        n_got = 0;
        n_ovr = 0;
        dat_ready = 1'b0;
        spi_ssal = 1'b0;
        idle(3);
        send_bits(16'h246E, 16);
        send_bits(16'hA563, 16);
        idle(6);
        check("ovr_pulses", n_ovr, 1);
        check("ovr_data",   dat_out, 16'hA563);
        check("ovr_valid",  dat_valid, 1'b1);
        check("ovr_nohs",   n_got, 0);
        spi_ssal = 1'b1;
        idle(6);
        dat_ready = 1'b1;
        idle(1);
        dat_ready = 1'b0;
        idle(1);
        check("ovr_consumed", dat_valid, 1'b0);

        // Short frame: 7 bits of 16'h89DD
        n_ferr = 0;
        spi_ssal = 1'b0;
        idle(3);
        send_bits(16'h89DD, 7);
        check("short_cnt7", bit_count, 5'd7);
        spi_ssal = 1'b1;
        idle(6);
        check("short_ferr",  n_ferr, 1);
        check("short_data",  dat_out, 16'hA563);
        check("short_valid", dat_valid, 1'b0);
        check("short_cnt0",  bit_count, 5'd0);

        // Reset after 9 bits, then a fresh 16'hFFFF frame
        spi_ssal = 1'b0;
        idle(3);
        send_bits(16'h1234, 9);
        check("mid_cnt9", bit_count, 5'd9);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_data",  dat_out,   16'h0000);
        check("mid_rst_valid", dat_valid, 1'b0);
        check("mid_rst_cnt",   bit_count, 5'd0);
        check("mid_rst_ferr",  frame_err, 1'b0);
        check("mid_rst_ovr",   overrun,   1'b0);
        idle(2);
        rst = 1'b1;
        send_bits(16'hF000, 4);
        check("post_rst_idle_cnt", bit_count, 5'd0);
        spi_ssal = 1'b1;
        idle(6);
        check("post_rst_no_ferr", n_ferr, 1);
        spi_ssal = 1'b0;
        idle(3);
        send_bits(16'hFFFF, 16);
        idle(2);
        check("post_rst_data",  dat_out,   16'hFFFF);
        check("post_rst_valid", dat_valid, 1'b1);
        spi_ssal = 1'b1;
        idle(6);
        dat_ready = 1'b1;
        idle(1);
        dat_ready = 1'b0;
        idle(1);

        // mclk activity with select high is ignored
        n_got = 0;
        send_bits(16'h5A5A, 8);
        check("desel_cnt_mid", bit_count, 5'd0);
        send_bits(16'h5A5A, 8);
        idle(6);
        check("desel_cnt_end", bit_count, 5'd0);
        check("desel_valid",   dat_valid, 1'b0);
        check("desel_data",    dat_out,   16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
